// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-list loader.
//   - ASCII byte constants recognised by the line parser
//   - parser state encoding
//   - is_digit() classifier
package freq_pkg;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  typedef enum logic [2:0] {
    LINE_START,
    SIGNED,
    DIGITS,
    WRITE,
    DONE,
    ERROR
  } state_e;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/dec_accum.sv
// Registered decimal accumulator.
//   clk, rst_n  : clock, async active-low reset (acc -> 0)
//   clear       : start a new value (acc treated as 0 this cycle)
//   load_digit  : shift in one decimal digit: acc = acc*10 + digit
//   digit       : digit value 0..9
//   acc         : current value, wraps modulo 2^DATA_W
module dec_accum #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load_digit,
  input  logic [3:0]        digit,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] acc_q, acc_d, base;

  // clear and load in the same cycle yields acc = digit (first digit of a line)
  always_comb begin
    base  = clear ? '0 : acc_q;
    acc_d = base;
    if (load_digit) acc_d = (base << 3) + (base << 1) + DATA_W'(digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/freq_loader.sv
// Parses an ASCII stream of signed decimal lines ("+13\n-7\n") and writes
// each value as a two's-complement word to consecutive RAM addresses.
//   in_valid/in_data/in_last/in_ready : byte stream in (transfer = valid & ready)
//   wr_en/wr_addr/wr_data              : one-cycle RAM write strobe
//   count                              : entries written so far
//   done                               : file consumed, last write issued (sticky)
//   err                                : parse or capacity error (sticky)
module freq_loader
  import freq_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 64,
  parameter int MAX_ENTRIES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] count,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic              neg_q, neg_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              live_q;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] acc, wval;
  logic              acc_clear, acc_load;
  logic              xfer, dig, full, term, bad;

  dec_accum #(.DATA_W(DATA_W)) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (acc_clear),
    .load_digit (acc_load),
    .digit      (in_data[3:0]),   // low nibble of '0'..'9' is the digit value
    .acc        (acc)
  );

  assign xfer = in_valid & in_ready;
  assign dig  = is_digit(in_data);
  assign full = ({1'b0, count_q} >= (ADDR_W+1)'(MAX_ENTRIES));
  assign wval = neg_q ? -acc : acc;

  // live_q holds in_ready low for the first cycle out of reset
  assign in_ready = live_q & ((state_q == LINE_START) || (state_q == SIGNED) ||
                              (state_q == DIGITS)     || (state_q == ERROR));
  assign wr_en    = (state_q == WRITE);
  // The write value is only final in WRITE (the last digit may land on the
  // terminating edge), so drive it live then and hold a registered copy after.
  assign wr_addr  = wr_en ? count_q : wr_addr_q;
  assign wr_data  = wr_en ? wval    : wr_data_q;
  assign count    = count_q;
  assign done     = done_q;
  assign err      = err_q;

  always_comb begin
    state_d   = state_q;
    neg_d     = neg_q;
    last_d    = last_q;
    done_d    = done_q;
    err_d     = err_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    acc_clear = 1'b0;
    acc_load  = 1'b0;
    term      = 1'b0;   // line completes on this byte
    bad       = 1'b0;   // byte is illegal here
    unique case (state_q)
      LINE_START: if (xfer) begin
        acc_clear = 1'b1;
        neg_d     = 1'b0;
        if (in_data == CH_PLUS || in_data == CH_MINUS) begin
          neg_d   = (in_data == CH_MINUS);
          state_d = SIGNED;
          bad     = in_last;
        end else if (dig) begin
          acc_load = 1'b1;
          state_d  = DIGITS;
          term     = in_last;
        end else if (in_data == CH_LF || in_data == CH_CR) begin
          if (in_last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          bad = 1'b1;
        end
      end
      SIGNED: if (xfer) begin
        if (dig) begin
          acc_load = 1'b1;
          state_d  = DIGITS;
          term     = in_last;
        end else begin
          bad = 1'b1;
        end
      end
      DIGITS: if (xfer) begin
        if (dig) begin
          acc_load = 1'b1;
          term     = in_last;
        end else if (in_data == CH_LF) begin
          term = 1'b1;
        end else if (in_data == CH_CR) begin
          term = in_last;   // CR is skipped unless the file ends on it
        end else begin
          bad = 1'b1;
        end
      end
      WRITE: begin
        count_d   = count_q + 1'b1;
        wr_addr_d = count_q;
        wr_data_d = wval;
        if (last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = LINE_START;
        end
      end
      DONE: ;
      ERROR: if (xfer && in_last) done_d = 1'b1;
      default: state_d = ERROR;
    endcase

    if (term) begin
      if (full) begin
        bad = 1'b1;
      end else begin
        state_d = WRITE;
        last_d  = in_last;
      end
    end
    if (bad) begin
      state_d = ERROR;
      err_d   = 1'b1;
      if (in_last) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LINE_START;
      neg_q     <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      live_q    <= 1'b0;
      count_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      neg_q     <= neg_d;
      last_q    <= last_d;
      done_q    <= done_d;
      err_q     <= err_d;
      live_q    <= 1'b1;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_freq_loader.sv
module tb_freq_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        sel = 1'b0;     // 0: default DUT, 1: MAX_ENTRIES=2 DUT

  logic        rdy0, wr0, done0, err0;
  logic [15:0] addr0, cnt0;
  logic [63:0] data0;
  logic        rdy1, wr1, done1, err1;
  logic [15:0] addr1, cnt1;
  logic [63:0] data1;

  int checks = 0;
  int errors = 0;
  int gap_bad = 0;
  int wide0 = 0, wide1 = 0, rdyhi0 = 0;
  logic prev_wr0 = 1'b0, prev_wr1 = 1'b0;
  logic [63:0] qa0[$], qd0[$], qa1[$], qd1[$];

  always #5 clk = ~clk;

  freq_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy0), .wr_en(wr0), .wr_addr(addr0),
    .wr_data(data0), .count(cnt0), .done(done0), .err(err0)
  );

  freq_loader #(.MAX_ENTRIES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy1), .wr_en(wr1), .wr_addr(addr1),
    .wr_data(data1), .count(cnt1), .done(done1), .err(err1)
  );

  // write capture and strobe-shape monitoring, away from the active edge
  always @(negedge clk) begin
    if (wr0) begin
      qa0.push_back(64'(addr0));
      qd0.push_back(data0);
      if (prev_wr0) wide0++;
      if (rdy0) rdyhi0++;
    end
    if (wr1) begin
      qa1.push_back(64'(addr1));
      qd1.push_back(data1);
      if (prev_wr1) wide1++;
    end
    prev_wr0 = wr0;
    prev_wr1 = wr1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // in_valid stays high across the whole string; each byte is held until it
  // transfers. With cg set, the byte after a '\n' must see exactly one
  // not-ready cycle (the WRITE), every other byte none.
  task automatic send_str(input string s, input bit last_end, input bit cg);
    for (int i = 0; i < s.len(); i++) begin
      int n;
      logic r;
      n = 0;
      in_data  = s[i];
      in_last  = last_end && (i == s.len() - 1);
      in_valid = 1'b1;
      forever begin
        @(negedge clk);
        r = sel ? rdy1 : rdy0;
        if (r) break;
        n++;
        if (n > 20) break;
      end
      if (n > 20) chk("timeout", 64'(n), 64'd0);
      if (cg && n != ((i > 0 && s[i-1] == 8'h0A) ? 1 : 0)) gap_bad++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_wr0(input int idx, input logic [63:0] a, input logic [63:0] d);
    if (idx < qa0.size()) begin
      chk("wr_addr", qa0[idx], a);
      chk("wr_data", qd0[idx], d);
    end else begin
      chk("wr_missing", 64'(qa0.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    // reset state while rst_n held low
    #3;
    chk("rst_ready", 64'(rdy0), 64'd0);
    chk("rst_wr_en", 64'(wr0), 64'd0);
    chk("rst_addr",  64'(addr0), 64'd0);
    chk("rst_data",  data0, 64'd0);
    chk("rst_count", 64'(cnt0), 64'd0);
    chk("rst_done",  64'(done0), 64'd0);
    chk("rst_err",   64'(err0), 64'd0);

    // three signed lines, last on final '\n'
    sel = 1'b0;
    do_reset();
    chk("ready_live", 64'(rdy0), 64'd1);
    send_str("+1\n-2\n+3\n", 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("t1_nwr", 64'(qa0.size()), 64'd3);
    chk_wr0(0, 64'd0, 64'd1);
    chk_wr0(1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE);
    chk_wr0(2, 64'd2, 64'd3);
    chk("t1_count", 64'(cnt0), 64'd3);
    chk("t1_done", 64'(done0), 64'd1);
    chk("t1_err", 64'(err0), 64'd0);
    chk("t1_ready_done", 64'(rdy0), 64'd0);
    chk("t1_gap", 64'(gap_bad), 64'd0);
    chk("t1_hold_addr", 64'(addr0), 64'd2);
    chk("t1_hold_data", data0, 64'd3);

    // CRLF, zero, empty line, last on a digit with no trailing newline
    do_reset();
    send_str("-1234567\r\n+0\n\n+42", 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("t2_nwr", 64'(qa0.size()), 64'd3);
    chk_wr0(0, 64'd0, 64'hFFFF_FFFF_FFED_2979);
    chk_wr0(1, 64'd1, 64'd0);
    chk_wr0(2, 64'd2, 64'd42);
    chk("t2_count", 64'(cnt0), 64'd3);
    chk("t2_done", 64'(done0), 64'd1);
    chk("t2_err", 64'(err0), 64'd0);

    // sign with no digits -> error, rest drained, done on last
    do_reset();
    send_str("+\n", 1'b0, 1'b0);
    #1;
    chk("t4_err_early", 64'(err0), 64'd1);
    chk("t4_done_early", 64'(done0), 64'd0);
    send_str("+5\n", 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_nwr", 64'(qa0.size()), 64'd0);
    chk("t4_done", 64'(done0), 64'd1);
    chk("t4_err", 64'(err0), 64'd1);
    chk("t4_count", 64'(cnt0), 64'd0);

    // capacity: MAX_ENTRIES=2
    sel = 1'b1;
    do_reset();
    send_str("+1\n+2\n+3\n", 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_nwr", 64'(qa1.size()), 64'd2);
    if (qa1.size() >= 2) begin
      chk("t5_addr1", qa1[1], 64'd1);
      chk("t5_data1", qd1[1], 64'd2);
    end
    chk("t5_err", 64'(err1), 64'd1);
    chk("t5_count", 64'(cnt1), 64'd2);
    chk("t5_done", 64'(done1), 64'd0);
    chk("t5_wide", 64'(wide1), 64'd0);

    // asynchronous reset mid-line
    sel = 1'b0;
    do_reset();
    send_str("+9\n+12", 1'b0, 1'b0);
    chk("t6_pre_count", 64'(cnt0), 64'd1);
    chk("t6_pre_data", data0, 64'd9);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_count", 64'(cnt0), 64'd0);
    chk("t6_async_data", data0, 64'd0);
    chk("t6_async_ready", 64'(rdy0), 64'd0);
    do_reset();
    send_str("+7\n", 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_nwr", 64'(qa0.size()), 64'd1);
    chk_wr0(0, 64'd0, 64'd7);
    chk("t6_count", 64'(cnt0), 64'd1);
    chk("t6_err", 64'(err0), 64'd0);

    chk("wr_pulse_wide", 64'(wide0), 64'd0);
    chk("ready_in_write", 64'(rdyhi0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
